out_channel_check: RTL and testbench
====================================

OUT_CHANNEL_CHECK -- requirements
Module: out_channel_check

Interface
REQ-001 SHALL have parameter MemoryElementWidth, default 12, width W of every out-channel word.
REQ-002 SHALL have parameter NOut, default 12, number of expected out words.
REQ-003 SHALL have parameter Depth, default 4, buffer entries, power of two and at least 2.
REQ-004 SHALL have port clock, input, 1 bit, driving clock.
REQ-005 SHALL have port reset, input, 1 bit, synchronous active-high restart.
REQ-006 SHALL have port in_valid, input, 1 bit, program presents an out word.
REQ-007 SHALL have port in_data, input, W bits, out word.
REQ-008 SHALL have port in_ready, output, 1 bit, block accepts the word.
REQ-009 SHALL have port program_done, input, 1 bit, level, program has issued its last out.
REQ-010 SHALL have port drain_en, input, 1 bit, permits one compare per cycle.
REQ-011 SHALL have port expected, input, NOut*W bits, word k at bits [k*W +: W], stable after reset.
REQ-012 SHALL have port finished, output, 1 bit, verdict reached.
REQ-013 SHALL have port success, output, 1 bit, all words matched; valid when finished.
REQ-014 SHALL have port mismatch_index, output, $clog2(NOut+1) bits, index of first failing word.
REQ-015 SHALL have port rx_count, output, $clog2(NOut+2) bits, words accepted; saturates at NOut+1.

Function
REQ-016 SHALL run FSM states RUN, PASS, FAIL; PASS and FAIL are terminal until reset.
REQ-017 in_ready SHALL be high only in RUN with the buffer not full; a transfer is in_valid && in_ready.
REQ-018 An accepted word SHALL become buffer head next cycle, so earliest compare is the cycle after acceptance.
REQ-019 In RUN with drain_en high and buffer non-empty, the head SHALL pop and be compared with expected[chk_count]; chk_count increments.
REQ-020 Push and pop in the same cycle SHALL both occur, leaving occupancy unchanged.
REQ-021 A head differing from its expected word SHALL move to FAIL next cycle with mismatch_index = chk_count.
REQ-022 A word popped when chk_count == NOut SHALL force FAIL with mismatch_index = NOut.
REQ-023 program_done high with the buffer empty in RUN SHALL give PASS if chk_count == NOut, otherwise FAIL with mismatch_index = chk_count.
REQ-024 Mismatch SHALL take priority over program_done in the same cycle.
REQ-025 finished SHALL be high exactly in PASS or FAIL; success SHALL be high exactly in PASS; both are registered.
REQ-026 Words presented after a verdict SHALL NOT be accepted, since in_ready is low.
REQ-027 Comparison SHALL be unsigned W-bit equality; no arithmetic wraps except the buffer pointers, modulo Depth.

Reset
REQ-028 reset SHALL, on the next clock edge and including mid-operation, empty the buffer, zero chk_count, rx_count, mismatch_index, finished and success, and enter RUN.
REQ-029 in_ready SHALL be high in the first cycle after reset is released.

Configuration
REQ-030 With OUT_CHANNEL_CAPTURE_EN defined, SHALL add input cap_addr ($clog2(NOut) bits) and output cap_data (W bits, one-cycle read latency) returning the k-th accepted word for k < NOut.
REQ-031 Without OUT_CHANNEL_CAPTURE_EN, SHALL have no capture memory or ports, and behaviour is otherwise identical.

Structure
REQ-032 Package out_channel_pkg SHALL hold the FSM state enum and the default width and count constants.
REQ-033 The buffer SHALL be sub-module out_channel_fifo: push, pop, full, empty, head, level.

Verification
REQ-034 Bench SHALL cover: expected = 3,2,1,0,3,2,1,0,0,1,2,3; send the same words, drain_en=1, then program_done -> finished=1, success=1, rx_count=12.
REQ-035 Bench SHALL cover: same stimulus but word 5 = 7 -> FAIL, mismatch_index=5, success=0, in_ready low thereafter.
REQ-036 Bench SHALL cover: drain_en=0 while sending 6 words with Depth=4 -> in_ready low after 4 transfers; raising drain_en resumes to PASS.
REQ-037 Bench SHALL cover: send only 11 correct words, then program_done -> FAIL, mismatch_index=11.
REQ-038 Bench SHALL cover: send 13 words -> FAIL, mismatch_index=12.
REQ-039 Bench SHALL cover: reset pulse after 6 words -> rx_count=0, finished=0; a full correct rerun passes. With OUT_CHANNEL_CAPTURE_EN, cap_addr=2 -> cap_data=1.

Source files
------------

// File: rtl/out_channel_pkg.sv
// rtl/out_channel_pkg.sv - shared state encoding and default sizes for the out-channel checker
package out_channel_pkg;

    localparam int DEFAULT_WIDTH = 12;
    localparam int DEFAULT_NOUT  = 12;
    localparam int DEFAULT_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_PASS = 2'd1,
        ST_FAIL = 2'd2
    } state_e;

endpackage

// File: rtl/out_channel_fifo.sv
// rtl/out_channel_fifo.sv - small circular buffer; head is registered so a push is visible next cycle
module out_channel_fifo
    import out_channel_pkg::*;
#(
    parameter int Width = DEFAULT_WIDTH,
    parameter int Depth = DEFAULT_DEPTH
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic [Width-1:0]           wdata,
    input  logic                       pop,
    output logic                       full,
    output logic                       empty,
    output logic [Width-1:0]           head,
    output logic [$clog2(Depth+1)-1:0] level
);

    localparam int PW = $clog2(Depth);
    localparam int LW = $clog2(Depth+1);

    logic [Width-1:0] mem_q [Depth];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             do_push, do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        level_d  = level_q;
        if (do_push && !do_pop) begin
            level_d = level_q + LW'(1);
        end else if (do_pop && !do_push) begin
            level_d = level_q - LW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign full  = (level_q == LW'(Depth));
    assign empty = (level_q == '0);
    assign head  = mem_q[rd_ptr_q];
    assign level = level_q;

endmodule

// File: rtl/out_channel_check.sv
// rtl/out_channel_check.sv - compares a program's out words against an expected list; OUT_CHANNEL_CAPTURE_EN adds a capture read port
module out_channel_check
    import out_channel_pkg::*;
#(
    parameter int MemoryElementWidth = DEFAULT_WIDTH,
    parameter int NOut               = DEFAULT_NOUT,
    parameter int Depth              = DEFAULT_DEPTH
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               in_valid,
    input  logic [MemoryElementWidth-1:0]      in_data,
    output logic                               in_ready,
    input  logic                               program_done,
    input  logic                               drain_en,
    input  logic [NOut*MemoryElementWidth-1:0] expected,
    output logic                               finished,
    output logic                               success,
    output logic [$clog2(NOut+1)-1:0]          mismatch_index,
`ifdef OUT_CHANNEL_CAPTURE_EN
    input  logic [$clog2(NOut)-1:0]            cap_addr,
    output logic [MemoryElementWidth-1:0]      cap_data,
`endif
    output logic [$clog2(NOut+2)-1:0]          rx_count
);

    localparam int W  = MemoryElementWidth;
    localparam int CW = $clog2(NOut+1);
    localparam int RW = $clog2(NOut+2);
    localparam int LW = $clog2(Depth+1);
    localparam logic [CW-1:0] NOUT_C = CW'(NOut);
    localparam logic [RW-1:0] RX_MAX = RW'(NOut+1);

    state_e        state_q, state_d;
    logic [CW-1:0] chk_q, chk_d;
    logic [CW-1:0] mis_q, mis_d;
    logic [RW-1:0] rx_q, rx_d;
    logic          finished_q, success_q;

    logic          fifo_full, fifo_empty;
    logic [W-1:0]  fifo_head;
    logic [LW-1:0] fifo_level;
    logic [W-1:0]  exp_word;
    logic          transfer, pop;

    assign in_ready = (state_q == ST_RUN) && !fifo_full;
    assign transfer = in_valid && in_ready;
    assign pop      = (state_q == ST_RUN) && drain_en && !fifo_empty;

    out_channel_fifo #(
        .Width (W),
        .Depth (Depth)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (transfer),
        .wdata (in_data),
        .pop   (pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head),
        .level (fifo_level)
    );

    // Past the last expected word there is nothing to select; an extra word fails regardless.
    always_comb begin
        exp_word = '0;
        if (chk_q < NOUT_C) begin
            exp_word = expected[int'(chk_q)*W +: W];
        end
    end

    always_comb begin
        state_d = state_q;
        chk_d   = chk_q;
        mis_d   = mis_q;
        rx_d    = rx_q;
        if (transfer && rx_q != RX_MAX) begin
            rx_d = rx_q + RW'(1);
        end
        if (state_q == ST_RUN) begin
            if (pop) begin
                if (chk_q == NOUT_C || fifo_head != exp_word) begin
                    state_d = ST_FAIL;
                    mis_d   = chk_q;
                end else begin
                    chk_d = chk_q + CW'(1);
                end
            end else if (program_done && fifo_level == '0) begin
                if (chk_q == NOUT_C) begin
                    state_d = ST_PASS;
                end else begin
                    state_d = ST_FAIL;
                    mis_d   = chk_q;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_RUN;
            chk_q      <= '0;
            mis_q      <= '0;
            rx_q       <= '0;
            finished_q <= 1'b0;
            success_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            chk_q      <= chk_d;
            mis_q      <= mis_d;
            rx_q       <= rx_d;
            finished_q <= (state_d != ST_RUN);
            success_q  <= (state_d == ST_PASS);
        end
    end

    assign finished       = finished_q;
    assign success        = success_q;
    assign mismatch_index = mis_q;
    assign rx_count       = rx_q;

`ifdef OUT_CHANNEL_CAPTURE_EN
    logic [W-1:0] cap_mem_q [NOut];
    logic [W-1:0] cap_data_q;

    always_ff @(posedge clock) begin
        if (transfer && int'(rx_q) < NOut) begin
            cap_mem_q[rx_q[$clog2(NOut)-1:0]] <= in_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cap_data_q <= '0;
        end else if (int'(cap_addr) < NOut) begin
            cap_data_q <= cap_mem_q[cap_addr];
        end else begin
            cap_data_q <= '0;
        end
    end

    assign cap_data = cap_data_q;
`endif

endmodule

// File: tb/tb_out_channel_check.sv
// tb/tb_out_channel_check.sv - scoreboard bench for out_channel_check verdicts and flow control
module tb_out_channel_check;

    localparam int W = 12;
    localparam int N = 12;
    localparam int D = 4;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic           in_valid = 1'b0;
    logic [W-1:0]   in_data = '0;
    logic           in_ready;
    logic           program_done = 1'b0;
    logic           drain_en = 1'b1;
    logic [N*W-1:0] expected;
    logic           finished;
    logic           success;
    logic [3:0]     mismatch_index;
    logic [3:0]     rx_count;
`ifdef OUT_CHANNEL_CAPTURE_EN
    logic [3:0]     cap_addr = '0;
    logic [W-1:0]   cap_data;
`endif

    out_channel_check #(
        .MemoryElementWidth (W),
        .NOut               (N),
        .Depth              (D)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ready       (in_ready),
        .program_done   (program_done),
        .drain_en       (drain_en),
        .expected       (expected),
        .finished       (finished),
        .success        (success),
        .mismatch_index (mismatch_index),
`ifdef OUT_CHANNEL_CAPTURE_EN
        .cap_addr       (cap_addr),
        .cap_data       (cap_data),
`endif
        .rx_count       (rx_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        int succ;
        int midx;
        int rx;
    } verdict_t;

    verdict_t sb[$];
    int golden[N] = '{3, 2, 1, 0, 3, 2, 1, 0, 0, 1, 2, 3};
    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        in_valid = 1'b0;
        program_done = 1'b0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Inputs change on the falling edge; in_ready depends only on registered state.
    task automatic send(input logic [W-1:0] d, output bit ok);
        ok = 1'b0;
        in_valid = 1'b1;
        in_data = d;
        for (int c = 0; c < 40; c++) begin
            if (finished) break;
            if (in_ready) begin
                @(negedge clock);
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
        in_valid = 1'b0;
    endtask

    task automatic expect_verdict(input int s, input int m, input int r);
        verdict_t v;
        v.succ = s;
        v.midx = m;
        v.rx = r;
        sb.push_back(v);
    endtask

    task automatic wait_verdict(input string tag);
        verdict_t v;
        for (int c = 0; c < 40; c++) begin
            if (finished) break;
            @(negedge clock);
        end
        check({tag, "_finished"}, finished, 1);
        check({tag, "_sb_nonempty"}, sb.size(), 1);
        if (sb.size() != 0) begin
            v = sb.pop_front();
            check({tag, "_success"}, success, v.succ);
            check({tag, "_mismatch_index"}, mismatch_index, v.midx);
            check({tag, "_rx_count"}, rx_count, v.rx);
        end
    endtask

    task automatic finish_program(input string tag);
        idle(8);
        program_done = 1'b1;
        wait_verdict(tag);
        program_done = 1'b0;
    endtask

    task automatic send_range(input int lo, input int hi, input string tag);
        bit ok;
        for (int k = lo; k <= hi; k++) begin
            send(golden[k][W-1:0], ok);
            check(tag, ok, 1);
        end
    endtask

    initial begin
        bit ok;
        for (int k = 0; k < N; k++) begin
            expected[k*W +: W] = golden[k][W-1:0];
        end

        // Clean pass
        do_reset();
        check("rst_finished", finished, 0);
        check("rst_success", success, 0);
        check("rst_rx_count", rx_count, 0);
        check("rst_mismatch_index", mismatch_index, 0);
        check("rst_in_ready", in_ready, 1);
        expect_verdict(1, 0, 12);
        send_range(0, 11, "pass_accept");
        finish_program("pass");

        // Word 5 corrupted
        do_reset();
        expect_verdict(0, 5, 7);
        for (int k = 0; k < N; k++) begin
            send((k == 5) ? W'(7) : golden[k][W-1:0], ok);
            if (!ok) break;
        end
        wait_verdict("bad5");
        in_valid = 1'b1;
        in_data = W'(1);
        idle(3);
        check("bad5_in_ready_low", in_ready, 0);
        check("bad5_no_accept", rx_count, 7);
        in_valid = 1'b0;

        // Back-pressure with drain disabled
        do_reset();
        drain_en = 1'b0;
        send_range(0, 3, "bp_accept");
        check("bp_full_in_ready", in_ready, 0);
        in_valid = 1'b1;
        in_data = golden[4][W-1:0];
        idle(3);
        check("bp_held_rx", rx_count, 4);
        check("bp_still_full", in_ready, 0);
        in_valid = 1'b0;
        drain_en = 1'b1;
        expect_verdict(1, 0, 12);
        send_range(4, 11, "bp_resume");
        finish_program("bp");

        // One word short
        do_reset();
        expect_verdict(0, 11, 11);
        send_range(0, 10, "short_accept");
        finish_program("short");

        // One word too many
        do_reset();
        expect_verdict(0, 12, 13);
        send_range(0, 11, "extra_accept");
        send(W'(0), ok);
        check("extra_13th_accept", ok, 1);
        wait_verdict("extra");

        // Reset mid-run, then full rerun
        do_reset();
        send_range(0, 5, "mid_accept");
        check("mid_rx_before", rx_count, 6);
        do_reset();
        check("mid_rst_rx_count", rx_count, 0);
        check("mid_rst_finished", finished, 0);
        check("mid_rst_success", success, 0);
        check("mid_rst_in_ready", in_ready, 1);
        expect_verdict(1, 0, 12);
        send_range(0, 11, "rerun_accept");
        finish_program("rerun");
`ifdef OUT_CHANNEL_CAPTURE_EN
        cap_addr = 4'd2;
        idle(2);
        check("cap_addr2", cap_data, golden[2]);
        cap_addr = 4'd11;
        idle(2);
        check("cap_addr11", cap_data, golden[11]);
`endif

        check("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
